// File: rtl/cell_vector_sequencer.sv
// Exhaustive stimulus/response sequencer for a combinational standard cell under test.
// Optional feature macro CELL_SEQ_MISR_EN adds a 16-bit MISR signature of the sampled outputs.
module cell_vector_sequencer #(
  parameter int N_IN       = 6,
  parameter int SETTLE_CYC = 10,
  parameter logic [(1<<N_IN)-1:0] EXP_TABLE = 64'h111F_111F_111F_FFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            zn_in,
  output logic [N_IN-1:0] vec_out,
  output logic            sample_vld,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_count,
  output logic [N_IN-1:0] first_err_vec
`ifdef CELL_SEQ_MISR_EN
  ,
  output logic [15:0]     signature
`endif
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             armed;
  logic             start_acc;
  logic             mismatch;
  logic [CNT_W-1:0] cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef CELL_SEQ_MISR_EN
  // Polynomial x^16 + x^12 + x^5 + 1; the serial input folds into the feedback tap.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
    logic fb;
    fb        = s[15] ^ b;
    misr_step = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  // armed stays low for the first edge after reset release so a start there is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    start_acc  = 1'b0;
    sample_vld = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start && armed) begin
          start_acc = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          sample_vld = 1'b1;
          if (vec_out == VEC_LAST) state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Unknown cell output at the sample point is treated as a mismatch.
  assign mismatch = sample_vld && (zn_in !== EXP_TABLE[vec_out]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out       <= '0;
      cnt           <= '0;
      pass          <= 1'b0;
      err_count     <= 8'd0;
      first_err_vec <= '0;
`ifdef CELL_SEQ_MISR_EN
      signature     <= 16'h0000;
`endif
    end else if (start_acc) begin
      vec_out       <= '0;
      cnt           <= '0;
      pass          <= 1'b0;
      err_count     <= 8'd0;
      first_err_vec <= '0;
`ifdef CELL_SEQ_MISR_EN
      signature     <= 16'hFFFF;
`endif
    end else if (busy) begin
      if (sample_vld) begin
        cnt <= '0;
        if (vec_out != VEC_LAST) vec_out <= vec_out + N_IN'(1);
        if (mismatch) begin
          err_count <= sat_inc(err_count);
          if (err_count == 8'd0) first_err_vec <= vec_out;
        end
`ifdef CELL_SEQ_MISR_EN
        signature <= misr_step(signature, zn_in);
`endif
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (done) begin
      pass <= (err_count == 8'd0);
    end
  end

endmodule

// File: tb/tb_cell_vector_sequencer.sv
// Bench for cell_vector_sequencer: table-driven runs, randomized responses, reset and start corners.
// Build with CELL_SEQ_MISR_EN defined to also check the signature output.
module tb_cell_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       zn_in;
  logic [5:0] vec_out;
  logic       sample_vld;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [5:0] first_err_vec;
`ifdef CELL_SEQ_MISR_EN
  logic [15:0] signature;
`endif

  int          total = 0;
  int          bad   = 0;
  int          mode  = 0;
  logic [63:0] flip_mask = 64'd0;

  always #5 clk = ~clk;

  cell_vector_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .zn_in         (zn_in),
    .vec_out       (vec_out),
    .sample_vld    (sample_vld),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_vec (first_err_vec)
`ifdef CELL_SEQ_MISR_EN
    ,
    .signature     (signature)
`endif
  );

  // OAI222 from its boolean definition: vec[5:4]=A1,A2  vec[3:2]=B1,B2  vec[1:0]=C1,C2.
  function automatic logic oai222(input logic [5:0] v);
    oai222 = !((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0]));
  endfunction

  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic b);
    logic [15:0] n;
    logic        fb;
    fb    = s[15] ^ b;
    n     = s << 1;
    n[0]  = fb;
    n[5]  = n[5] ^ fb;
    n[12] = n[12] ^ fb;
    misr_ref = n;
  endfunction

  // Models the cell (and faulty variants of it) driving zn_in.
  always_comb begin
    case (mode)
      1:       zn_in = 1'b1;
      2:       zn_in = 1'b0;
      3:       zn_in = oai222(vec_out) ^ (vec_out == 6'd5);
      4:       zn_in = oai222(vec_out) ^ flip_mask[vec_out];
      default: zn_in = oai222(vec_out);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"},   32'(vec_out), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_svld"},  32'(sample_vld), 32'd0);
    check({tag, "_pass"},  32'(pass), 32'd0);
    check({tag, "_err"},   32'(err_count), 32'd0);
    check({tag, "_first"}, 32'(first_err_vec), 32'd0);
`ifdef CELL_SEQ_MISR_EN
    check({tag, "_sig"},   32'(signature), 32'd0);
`endif
  endtask

  // Called at a negedge; start is raised in that cycle. Returns at the negedge after done.
  task automatic run_one(input string tag, input bit fixed, input int e_err, input int e_first,
                         input bit poke, output logic [15:0] sig_model);
    int          cyc     = 0;
    int          nbusy   = 0;
    int          nsamp   = 0;
    int          done_at = -1;
    int          m_err   = 0;
    int          m_first = 0;
    logic [15:0] m_sig   = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done_at < 0 && cyc < 800) begin
      if (busy) nbusy++;
      if (sample_vld) begin
        check({tag, "_sample_vec"}, 32'(vec_out), 32'(nsamp));
        if (zn_in !== oai222(6'(nsamp))) begin
          if (m_err == 0) m_first = nsamp;
          if (m_err < 255) m_err++;
        end
        m_sig = misr_ref(m_sig, zn_in);
        nsamp++;
      end
      if (poke && cyc == 100) start = 1'b1;
      if (poke && cyc == 101) start = 1'b0;
      if (done) begin
        done_at = cyc;
        if (poke) start = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_at"}, 32'(done_at), 32'd641);
    check({tag, "_busy_cyc"}, 32'(nbusy), 32'd640);
    check({tag, "_samples"}, 32'(nsamp), 32'd64);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_vec_hold"}, 32'(vec_out), 32'd63);
    check({tag, "_pass"}, 32'(pass), 32'(m_err == 0));
    check({tag, "_err"}, 32'(err_count), 32'(m_err));
    if (m_err != 0) check({tag, "_first"}, 32'(first_err_vec), 32'(m_first));
    if (fixed) begin
      check({tag, "_err_tbl"}, 32'(err_count), 32'(e_err));
      check({tag, "_pass_tbl"}, 32'(pass), 32'(e_err == 0));
      if (e_err != 0) check({tag, "_first_tbl"}, 32'(first_err_vec), 32'(e_first));
    end
`ifdef CELL_SEQ_MISR_EN
    check({tag, "_sig"}, 32'(signature), 32'(m_sig));
`endif
    sig_model = m_sig;
  endtask

  typedef struct {
    string name;
    int    mode;
    int    exp_err;
    int    exp_first;
    bit    poke;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] sig_golden;
  logic [15:0] sig_flip;
  logic [15:0] sig_tmp;
  bit          reached;

  initial begin
    tbl[0] = '{"golden",    0,  0,  0, 1'b0};
    tbl[1] = '{"tied1",     1, 27, 21, 1'b0};
    tbl[2] = '{"tied0",     2, 37,  0, 1'b0};
    tbl[3] = '{"flip5",     3,  1,  5, 1'b0};
    tbl[4] = '{"poke",      0,  0,  0, 1'b1};
    tbl[5] = '{"back2back", 0,  0,  0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Release reset with start already high: that start must be dropped.
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("release_start_ignored", 32'(busy), 32'd0);

    sig_golden = 16'h0;
    sig_flip   = 16'h0;
    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].mode;
      run_one(tbl[i].name, 1'b1, tbl[i].exp_err, tbl[i].exp_first, tbl[i].poke, sig_tmp);
      if (i == 0) sig_golden = sig_tmp;
      if (i == 3) sig_flip = sig_tmp;
    end
`ifdef CELL_SEQ_MISR_EN
    check("sig_differs", 32'(sig_golden != sig_flip), 32'd1);
`endif

    for (int r = 0; r < 3; r++) begin
      mode      = 4;
      flip_mask = {$urandom, $urandom};
      run_one($sformatf("rand%0d", r), 1'b0, 0, 0, 1'b0, sig_tmp);
    end

    // Abort a run part-way with an asynchronous reset.
    mode  = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 700 && !reached; k++) begin
      if (vec_out == 6'd30) reached = 1'b1;
      else @(negedge clk);
    end
    check("reach_vec30", 32'(reached), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rerelease_start_ignored", 32'(busy), 32'd0);
    run_one("after_rst", 1'b1, 0, 0, 1'b0, sig_tmp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
